// File: rtl/add_pkg.sv
// Shared types and constants for the add/accumulate sequencer.
//
// Contents:
//   op_t         operation codes carried on in_op
//   state_t      sequencer FSM states
//   ADD_W        width of the external split-capable adder
//   LANE_W       width of one byte lane when the adder is split
//   ACC_W        accumulator width (two adder passes)
//   lowLaneCarry recovers the carry out of the low byte lane
package add_pkg;

  localparam int ADD_W  = 16;
  localparam int LANE_W = 8;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    CLEAR  = 2'b00,
    ADD16  = 2'b01,
    ADD8X2 = 2'b10,
    ADD32  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXEC_LO = 2'b01,
    EXEC_HI = 2'b10,
    RESP    = 2'b11
  } state_t;

  // The adder only exposes its top carry, so the low lane's carry is
  // rebuilt from the lane MSBs: both operands set always carries, and
  // exactly one set carries when the sum bit came out clear.
  // Valid only when the lane's carry-in is zero.
  function automatic logic lowLaneCarry(input logic aMsb,
                                        input logic bMsb,
                                        input logic sMsb);
    return (aMsb & bMsb) | ((aMsb ^ bMsb) & ~sMsb);
  endfunction

endpackage

// File: rtl/add_accumulate_sequencer.sv
// Sequencer and accumulator in front of an external 16-bit adder.
// An accepted operation runs one adder pass (two for ADD32, chained
// through the carry) and the result is offered until the consumer
// takes it.
//
// Ports:
//   clk, rst                async active-high reset
//   in_valid/in_ready       operation handshake, in_op + in_data
//   add_a/add_b/add_ci/
//   add_split               drive the external adder
//   add_s/add_co            adder result, combinational
//   out_valid/out_ready     result handshake
//   out_acc, out_cy         accumulator and carry flags
module add_accumulate_sequencer
  import add_pkg::*;
#(
  parameter int ACC_W = add_pkg::ACC_W,
  parameter int ADD_W = add_pkg::ADD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [ACC_W-1:0] in_data,
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  output logic             add_ci,
  output logic             add_split,
  input  logic [ADD_W-1:0] add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [1:0]       out_cy
);

  state_t           r_state;
  state_t           w_nextState;
  op_t              r_op;
  logic [ACC_W-1:0] r_data;
  logic [ACC_W-1:0] r_acc;
  logic [1:0]       r_cy;
  logic             r_cyMid;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == RESP);
  assign out_acc   = r_acc;
  assign out_cy    = r_cy;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and adder drive. The adder sees zeros except during the
  // two execute states, so it is quiet while idle or waiting on output.
  always_comb begin
    w_nextState = r_state;
    add_a       = '0;
    add_b       = '0;
    add_ci      = 1'b0;
    add_split   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) w_nextState = EXEC_LO;
      end
      EXEC_LO: begin
        add_a       = r_acc[ADD_W-1:0];
        add_b       = r_data[ADD_W-1:0];
        add_split   = (r_op == ADD8X2);
        w_nextState = (r_op == ADD32) ? EXEC_HI : RESP;
      end
      EXEC_HI: begin
        add_a       = r_acc[ACC_W-1:ADD_W];
        add_b       = r_data[ACC_W-1:ADD_W];
        add_ci      = r_cyMid;
        w_nextState = RESP;
      end
      RESP: begin
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand latch and accumulator update. The upper accumulator word is
  // only touched by CLEAR and the second ADD32 pass; the low-word carry
  // of ADD32 is parked in r_cyMid to feed the high pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= CLEAR;
      r_data  <= '0;
      r_acc   <= '0;
      r_cy    <= '0;
      r_cyMid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op   <= op_t'(in_op);
            r_data <= in_data;
          end
        end
        EXEC_LO: begin
          case (r_op)
            CLEAR: begin
              r_acc <= '0;
              r_cy  <= 2'b00;
            end
            ADD16: begin
              r_acc[ADD_W-1:0] <= add_s;
              r_cy             <= {add_co, 1'b0};
            end
            ADD8X2: begin
              r_acc[ADD_W-1:0] <= add_s;
              r_cy <= {add_co, lowLaneCarry(r_acc[LANE_W-1],
                                            r_data[LANE_W-1],
                                            add_s[LANE_W-1])};
            end
            ADD32: begin
              r_acc[ADD_W-1:0] <= add_s;
              r_cyMid          <= add_co;
            end
            default: r_acc <= r_acc;
          endcase
        end
        EXEC_HI: begin
          r_acc[ACC_W-1:ADD_W] <= add_s;
          r_cy                 <= {add_co, r_cyMid};
        end
        default: r_cy <= r_cy;
      endcase
    end
  end

endmodule

// File: tb/tb_add_accumulate_sequencer.sv
module tb_add_accumulate_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_ci;
  logic        add_split;
  logic [15:0] add_s;
  logic        add_co;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_acc;
  logic [1:0]  out_cy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mAcc;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_ADD16 = 2'b01;
  localparam logic [1:0] OP_ADD8X2 = 2'b10;
  localparam logic [1:0] OP_ADD32 = 2'b11;

  always #5 clk = ~clk;

  add_accumulate_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_split(add_split),
    .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_cy(out_cy)
  );

  // Behavioural split-capable 16-bit adder standing in for the sibling instance.
  logic [8:0] lo9;
  logic [8:0] hi9;
  logic       cMid;
  always_comb begin
    lo9    = {1'b0, add_a[7:0]} + {1'b0, add_b[7:0]} + {8'd0, add_ci};
    cMid   = add_split ? 1'b0 : lo9[8];
    hi9    = {1'b0, add_a[15:8]} + {1'b0, add_b[15:8]} + {8'd0, cMid};
    add_s  = {hi9[7:0], lo9[7:0]};
    add_co = hi9[8];
  end

  // Reference result of one operation from plain arithmetic.
  task automatic modelOp(input logic [1:0] op, input logic [31:0] acc, input logic [31:0] d,
                         output logic [31:0] nAcc, output logic [1:0] cy, output int lat);
    logic [16:0] s17;
    logic [8:0]  l9;
    logic [8:0]  h9;
    logic [32:0] s33;
    case (op)
      OP_CLEAR: begin nAcc = 32'd0; cy = 2'b00; lat = 2; end
      OP_ADD16: begin
        s17 = {1'b0, acc[15:0]} + {1'b0, d[15:0]};
        nAcc = {acc[31:16], s17[15:0]}; cy = {s17[16], 1'b0}; lat = 2;
      end
      OP_ADD8X2: begin
        l9 = {1'b0, acc[7:0]} + {1'b0, d[7:0]};
        h9 = {1'b0, acc[15:8]} + {1'b0, d[15:8]};
        nAcc = {acc[31:16], h9[7:0], l9[7:0]}; cy = {h9[8], l9[8]}; lat = 2;
      end
      default: begin
        s33 = {1'b0, acc} + {1'b0, d};
        s17 = {1'b0, acc[15:0]} + {1'b0, d[15:0]};
        nAcc = s33[31:0]; cy = {s33[32], s17[16]}; lat = 3;
      end
    endcase
  endtask

  // Drives one operation through both handshakes and reports what was seen.
  task automatic runOp(input logic [1:0] op, input logic [31:0] d,
                       output logic [31:0] obsAcc, output logic [1:0] obsCy, output int obsLat,
                       output logic obsSplitLo, output logic obsCiHi,
                       output logic obsReadyAfter, output logic obsValidAfter);
    int edges;
    obsSplitLo = 1'b0;
    obsCiHi = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 20) begin
      if (edges == 1) obsSplitLo = add_split;
      if (edges == 2) obsCiHi = add_ci;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    obsLat = out_valid ? edges : 99;
    obsAcc = out_acc;
    obsCy = out_cy;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    obsReadyAfter = in_ready;
    obsValidAfter = out_valid;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] d);
    logic [31:0] a; logic [1:0] c; int l; logic s, ci, r, v;
    runOp(op, d, a, c, l, s, ci, r, v);
  endtask

  task automatic preload(input logic [31:0] value);
    applyStimulus(OP_CLEAR, 32'd0);
    applyStimulus(OP_ADD32, value);
    mAcc = value;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = 32'd0; out_ready = 1'b0;
    #12;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    vectors++;
    if (out_acc !== 32'd0 || out_cy !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_acc acc=%h cy=%b required 00000000/00", out_acc, out_cy);
    end
    vectors++;
    if ({add_a, add_b, add_ci, add_split} !== 34'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_adder_drive a=%h b=%h ci=%b split=%b required zero", add_a, add_b, add_ci, add_split);
    end
    @(negedge clk);
    rst = 1'b0;
    mAcc = 32'd0;
  endtask

  task automatic test_clear();
    logic [31:0] a, ea; logic [1:0] c, ec; int l, el; logic s, ci, r, v;
    preload(32'hDEADBEEF);
    modelOp(OP_CLEAR, mAcc, 32'h5555AAAA, ea, ec, el);
    runOp(OP_CLEAR, 32'h5555AAAA, a, c, l, s, ci, r, v);
    mAcc = ea;
    vectors++;
    if (a !== ea || c !== ec) begin
      miscompares++;
      $display("[TB] FAIL clear_result acc=%h cy=%b required %h/%b", a, c, ea, ec);
    end
    vectors++;
    if (l !== el) begin
      miscompares++;
      $display("[TB] FAIL clear_latency got %0d required %0d", l, el);
    end
    vectors++;
    if (r !== 1'b1 || v !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_release in_ready=%b out_valid=%b required 1/0", r, v);
    end
  endtask

  task automatic test_add16();
    logic [31:0] a; logic [1:0] c; int l; logic s, ci, r, v;
    preload(32'h1234FFFF);
    runOp(OP_ADD16, 32'h00000001, a, c, l, s, ci, r, v);
    mAcc = a;
    vectors++;
    if (a !== 32'h12340000 || c !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL add16_wrap acc=%h cy=%b required 12340000/10", a, c);
    end
    vectors++;
    if (l !== 2 || s !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add16_timing lat=%0d split=%b required 2/0", l, s);
    end
  endtask

  task automatic test_add8x2();
    logic [31:0] a; logic [1:0] c; int l; logic s, ci, r, v;
    preload(32'h000080FF);
    runOp(OP_ADD8X2, 32'h00008001, a, c, l, s, ci, r, v);
    mAcc = a;
    vectors++;
    if (a !== 32'h00000000 || c !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL add8x2_lanes acc=%h cy=%b required 00000000/11", a, c);
    end
    vectors++;
    if (s !== 1'b1 || l !== 2) begin
      miscompares++;
      $display("[TB] FAIL add8x2_split split=%b lat=%0d required 1/2", s, l);
    end
    preload(32'hABCD00FF);
    runOp(OP_ADD8X2, 32'h00000001, a, c, l, s, ci, r, v);
    mAcc = a;
    vectors++;
    if (a !== 32'hABCD0000 || c !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL add8x2_no_cross acc=%h cy=%b required ABCD0000/01", a, c);
    end
  endtask

  task automatic test_add32_carry();
    logic [31:0] a; logic [1:0] c; int l; logic s, ci, r, v;
    preload(32'h0000FFFF);
    runOp(OP_ADD32, 32'h00000001, a, c, l, s, ci, r, v);
    mAcc = a;
    vectors++;
    if (a !== 32'h00010000 || c !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL add32_chain acc=%h cy=%b required 00010000/01", a, c);
    end
    vectors++;
    if (ci !== 1'b1 || l !== 3) begin
      miscompares++;
      $display("[TB] FAIL add32_hi_pass ci=%b lat=%0d required 1/3", ci, l);
    end
  endtask

  task automatic test_add32_wrap();
    logic [31:0] a; logic [1:0] c; int l; logic s, ci, r, v;
    preload(32'hFFFFFFFF);
    runOp(OP_ADD32, 32'h00000001, a, c, l, s, ci, r, v);
    mAcc = a;
    vectors++;
    if (a !== 32'h00000000 || c !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL add32_wrap acc=%h cy=%b required 00000000/11", a, c);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    int edges;
    preload(32'h00000010);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_ADD16; in_data = 32'h00000005;
    @(posedge clk);
    @(negedge clk);
    in_op = OP_CLEAR; in_data = 32'hFFFFFFFF;
    edges = 0;
    while (!out_valid && edges < 10) begin
      @(posedge clk); @(negedge clk); edges++;
    end
    held = out_acc;
    vectors++;
    if (held !== 32'h00000015) begin
      miscompares++;
      $display("[TB] FAIL stall_result acc=%h required 00000015", held);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== held) begin
        miscompares++;
        $display("[TB] FAIL stall_hold cycle %0d valid=%b in_ready=%b acc=%h required 1/0/%h",
                 i, out_valid, in_ready, out_acc, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== held) begin
      miscompares++;
      $display("[TB] FAIL stall_release in_ready=%b valid=%b acc=%h required 1/0/%h", in_ready, out_valid, out_acc, held);
    end
    mAcc = held;
  endtask

  task automatic test_reset_abort();
    logic seenValid;
    preload(32'h0F0F0F0F);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_ADD32; in_data = 32'h11111111;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (add_b !== 16'h1111) begin
      miscompares++;
      $display("[TB] FAIL abort_in_hi add_b=%h required 1111", add_b);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_acc !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_reset acc=%h valid=%b in_ready=%b required 00000000/0/1", out_acc, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seenValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seenValid = 1'b1;
    end
    vectors++;
    if (seenValid !== 1'b0 || out_acc !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_response valid_seen=%b acc=%h required 0/00000000", seenValid, out_acc);
    end
    mAcc = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] a, ea, d; logic [1:0] c, ec, op; int l, el; logic s, ci, r, v;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if (op == OP_CLEAR && $urandom_range(0, 2) != 0) op = OP_ADD32;
      d = $urandom;
      modelOp(op, mAcc, d, ea, ec, el);
      runOp(op, d, a, c, l, s, ci, r, v);
      mAcc = ea;
      vectors++;
      if (a !== ea || c !== ec || l !== el || r !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL random_%0d op=%0d data=%h acc=%h cy=%b lat=%0d rdy=%b required %h/%b/%0d/1",
                 i, op, d, a, c, l, r, ea, ec, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_add16();
    test_add8x2();
    test_add32_carry();
    test_add32_wrap();
    test_stall();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
